bram_port_arbiter: RTL
======================

Name: bram_port_arbiter

Overview:
- Shares BRAM port A between two requesters: the CPU datapath (port c: fetch/load/store via FSM) and the phone/peripheral write-read engine (port p).
- Issues at most one access per clock. CPU has fixed priority, bounded by a starvation counter that forces a grant to p.
- Sits between the LS_CNTL address mux / FSM and the bram instance. Routes registered read-return (rvalid) back to the requester that issued the read.

Parameters:
- ADDR_W, 16, address width of BRAM port A.
- DATA_W, 16, data width.
- STARVE_LIMIT, 3, consecutive cycles p may lose arbitration before it is forced to win (legal range 1..15).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- c_req  in  1  CPU access request; held with c_we/c_addr/c_wdata stable until c_gnt.
- c_we  in  1  CPU write enable (1 = store, 0 = read).
- c_addr  in  ADDR_W  CPU address.
- c_wdata  in  DATA_W  CPU store data.
- c_gnt  out  1  CPU access issued this cycle.
- c_rvalid  out  1  CPU read data valid this cycle.
- c_rdata  out  DATA_W  CPU read data.
- p_req, p_we, p_addr, p_wdata  in  1/1/ADDR_W/DATA_W  peripheral request set, same rules as CPU.
- p_gnt  out  1  peripheral access issued this cycle.
- p_rvalid  out  1  peripheral read data valid.
- p_rdata  out  DATA_W  peripheral read data.
- mem_addr  out  ADDR_W  to bram addr_a.
- mem_data  out  DATA_W  to bram data_a.
- mem_we  out  1  to bram we_a.
- mem_q  in  DATA_W  from bram q_a (1-cycle registered read).
- starve_cnt  out  4  current p loss count (debug).

Behaviour:
- Reset (rst=0, async): starve_cnt=0, c_rvalid=0, p_rvalid=0, last_owner=c. Combinational outputs follow the rules below with registers at reset values.
- Arbitration is combinational in the request cycle:
  - force_p = p_req & (starve_cnt == STARVE_LIMIT).
  - p_gnt = p_req & (~c_req | force_p).
  - c_gnt = c_req & ~p_gnt.
  - c_gnt and p_gnt are never both 1.
- Memory drive:
  - p_gnt: mem_addr=p_addr, mem_data=p_wdata, mem_we=p_we.
  - c_gnt: mem_addr=c_addr, mem_data=c_wdata, mem_we=c_we.
  - Idle: mem_addr=c_addr, mem_data=c_wdata, mem_we=0. The CPU fetch address stays presented.
- mem_we is high only in a grant cycle of a write.
- Read return latency 1 cycle:
  - c_rvalid <= c_gnt & ~c_we; p_rvalid <= p_gnt & ~p_we.
  - last_owner <= p when p_gnt, c when c_gnt; held when idle.
  - c_rdata = mem_q, p_rdata = mem_q, both driven unconditionally. Valid only with the matching rvalid.
- Writes produce no rvalid. Write completes at the grant edge.
- Starvation counter (4-bit, saturating at STARVE_LIMIT):
  - p_req & ~p_gnt: starve_cnt <= min(starve_cnt+1, STARVE_LIMIT).
  - p_gnt or ~p_req: starve_cnt <= 0.
- Back-to-back: a requester holding req high across cycles is granted again each cycle it wins. There is no dead cycle between grants.
- Requester dropping req before its gnt: request is withdrawn, with no side effects. starve_cnt clears if it was p.
- Simultaneous read by p and write by c in the same cycle is impossible (single grant). Read-after-write to the same address on consecutive grants returns the new data.
- Reset asserted mid-read: the pending rvalid is discarded (0 after reset). No grant is issued while rst=0 is sampled.

Test Plan:
- Reset then c_req=1, c_we=0, c_addr=0x0010, bram[0x10]=0xBEEF; p_req=0 -> c_gnt=1 same cycle, mem_we=0; next cycle c_rvalid=1, c_rdata=0xBEEF, p_rvalid=0.
- p_req=1, p_we=1, p_addr=0x0200, p_wdata=0x00A5, c_req=0 -> p_gnt=1, mem_we=1, mem_addr=0x0200; then p read of 0x0200 -> p_rvalid next cycle, p_rdata=0x00A5.
- c_req and p_req both held high 8 cycles, STARVE_LIMIT=3 -> grant pattern c,c,c,p,c,c,c,p; starve_cnt goes 1,2,3,0,1,2,3,0.
- Contention with STARVE_LIMIT=1 -> strict alternation c,p,c,p; p_req dropped after 1 loss -> starve_cnt returns to 0 next cycle.
- c read granted, rst pulsed low for 1 cycle before the rvalid edge -> c_rvalid stays 0, starve_cnt=0, next c_req granted normally.
- c_we=1 write 0x1234 to 0x0050 followed by p read of 0x0050 next cycle -> p_rdata=0x1234 with p_rvalid=1.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares BRAM port A between the CPU (c) and peripheral (p) requesters,
// CPU-priority with a starvation bound, and steers the 1-cycle read return to the issuer.
module bram_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_gnt,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q,
    output logic [3:0]        starve_cnt
);
    typedef enum logic {OWN_C = 1'b0, OWN_P = 1'b1} owner_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       rd_pend_q, rd_pend_d;
    owner_e     owner_q, owner_d;
    logic       force_p;

    always_comb begin
        force_p      = p_req & (starve_cnt_q >= LIMIT);
        // grants are suppressed while reset is held so nothing reaches the BRAM
        p_gnt        = rst & p_req & (~c_req | force_p);
        c_gnt        = rst & c_req & ~p_gnt;
        mem_addr     = p_gnt ? p_addr : c_addr;
        mem_data     = p_gnt ? p_wdata : c_wdata;
        mem_we       = p_gnt ? p_we : (c_gnt & c_we);
        rd_pend_d    = (p_gnt & ~p_we) | (c_gnt & ~c_we);
        owner_d      = p_gnt ? OWN_P : (c_gnt ? OWN_C : owner_q);
        starve_cnt_d = (~p_req | p_gnt) ? 4'd0
                     : (starve_cnt_q >= LIMIT ? LIMIT : starve_cnt_q + 4'd1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= 4'd0;
            rd_pend_q    <= 1'b0;
            owner_q      <= OWN_C;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rd_pend_q    <= rd_pend_d;
            owner_q      <= owner_d;
        end
    end

    assign c_rvalid   = rd_pend_q & (owner_q == OWN_C);
    assign p_rvalid   = rd_pend_q & (owner_q == OWN_P);
    assign c_rdata    = mem_q;
    assign p_rdata    = mem_q;
    assign starve_cnt = starve_cnt_q;

    a_one_grant: assert property (@(posedge clk) disable iff (!rst) !(c_gnt && p_gnt));
endmodule
